// File: rtl/seven_seg_scanner_if.sv
// Frame-load handshake between a display producer (master) and seven_seg_scanner (slave).
// A frame transfers on any clk edge where load_valid and load_ready are both high.
interface seven_seg_scanner_if #(
   parameter int unsigned DIGITS = 4
) ();
   logic                load_valid;
   logic                load_ready;
   logic [4*DIGITS-1:0] digits_in;
   logic [DIGITS-1:0]   dp_in;
   logic [DIGITS-1:0]   blank_in;

   modport master (
      output load_valid,
      output digits_in,
      output dp_in,
      output blank_in,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  digits_in,
      input  dp_in,
      input  blank_in,
      output load_ready
   );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment driver: time-slices DIGITS hex digits with PWM brightness,
// leading-zero blanking and a double-buffered frame load applied only at frame boundaries.
module seven_seg_scanner #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned DIV_W  = 18
) (
   input  logic                      clk,
   input  logic                      reset,
   seven_seg_scanner_if.slave        load_if,
   input  logic [3:0]                bright,
   input  logic                      lz_en,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [DIGITS-1:0]         an,
   output logic                      frame_tick
);

   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

   logic [DIV_W-1:0]    slot_q;
   logic [IdxW-1:0]     idx_q;
   logic [3:0]          bright_q;
   logic                frame_tick_q;

   logic [4*DIGITS-1:0] act_digits_q, pend_digits_q;
   logic [DIGITS-1:0]   act_dp_q, pend_dp_q;
   logic [DIGITS-1:0]   act_blank_q, pend_blank_q;
   logic                pend_full_q;

   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic                slot_wrap;
   logic                boundary;
   logic                xfer;
   logic [DIGITS-1:0]   lz_blank;
   logic [3:0]          cur_hex;
   logic                cur_dp;
   logic                cur_dark;
   logic [DIGITS-1:0]   cur_an;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign slot_wrap          = &slot_q;
   assign boundary           = slot_wrap && (idx_q == LastIdx);
   assign load_if.load_ready = ~pend_full_q;
   assign xfer               = load_if.load_valid && ~pend_full_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q       <= '0;
         idx_q        <= '0;
         bright_q     <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         slot_q       <= slot_q + DIV_W'(1);
         if (slot_wrap) begin
            idx_q <= (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
         end
         if (slot_q == '0) begin
            bright_q <= bright;
         end
         frame_tick_q <= boundary;
      end
   end

   // A load arriving on the boundary cycle only fills the pending buffer; never bypasses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_digits_q  <= '0;
         act_dp_q      <= '0;
         act_blank_q   <= '1;
         pend_digits_q <= '0;
         pend_dp_q     <= '0;
         pend_blank_q  <= '0;
         pend_full_q   <= 1'b0;
      end else if (boundary && pend_full_q) begin
         act_digits_q  <= pend_digits_q;
         act_dp_q      <= pend_dp_q;
         act_blank_q   <= pend_blank_q;
         pend_full_q   <= 1'b0;
      end else if (xfer) begin
         pend_digits_q <= load_if.digits_in;
         pend_dp_q     <= load_if.dp_in;
         pend_blank_q  <= load_if.blank_in;
         pend_full_q   <= 1'b1;
      end
   end

   // Digit i is a leading zero when it and every digit above it are zero; digit 0 never is.
   always_comb begin
      logic upper_zero;
      lz_blank   = '0;
      upper_zero = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         upper_zero  = upper_zero && (act_digits_q[4*i +: 4] == 4'h0);
         lz_blank[i] = lz_en && upper_zero;
      end
   end

   always_comb begin
      cur_hex  = 4'h0;
      cur_dp   = 1'b0;
      cur_dark = 1'b1;
      cur_an   = '1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IdxW'(i)) begin
            cur_hex   = act_digits_q[4*i +: 4];
            cur_dp    = act_dp_q[i];
            cur_dark  = act_blank_q[i] || lz_blank[i];
            cur_an[i] = 1'b0;
         end
      end
      // PWM: the top four slot bits form the duty ramp compared against brightness.
      if (slot_q[DIV_W-1 -: 4] > bright_q) begin
         cur_dark = 1'b1;
      end

      seg_d = 7'h7F;
      dp_d  = 1'b1;
      an_d  = '1;
      if (!cur_dark) begin
         seg_d = hex_to_seg(cur_hex);
         dp_d  = ~cur_dp;
         an_d  = cur_an;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
         an_q  <= '1;
      end else begin
         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: a 4-digit/DIV_W=4 instance for most scenarios and
// an 8-digit/DIV_W=5 instance for the wide-scan case. Outputs are sampled on falling edges.
module tb_seven_seg_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] bright;
   logic       lz_en;

   logic [6:0] seg, seg8;
   logic       dp, dp8;
   logic [3:0] an;
   logic [7:0] an8;
   logic       frame_tick, frame_tick8;

   int n_checks = 0;
   int n_fail   = 0;

   seven_seg_scanner_if #(.DIGITS(4)) lif ();
   seven_seg_scanner_if #(.DIGITS(8)) lif8 ();

   seven_seg_scanner #(.DIGITS(4), .DIV_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_if    (lif),
      .bright     (bright),
      .lz_en      (lz_en),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_tick (frame_tick)
   );

   seven_seg_scanner #(.DIGITS(8), .DIV_W(5)) dut8 (
      .clk        (clk),
      .reset      (reset),
      .load_if    (lif8),
      .bright     (bright),
      .lz_en      (lz_en),
      .seg        (seg8),
      .dp         (dp8),
      .an         (an8),
      .frame_tick (frame_tick8)
   );

   always #5 clk = ~clk;

   // Bounded wait for the next frame_tick of either instance; timeout counts as a failure.
   task automatic wait_tick(input bit wide, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk);
         seen = wide ? frame_tick8 : frame_tick;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL frame_tick_wait: got no pulse within %0d cycles, want one", limit);
      end
   endtask

   task automatic load4(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
      @(negedge clk);
      lif.load_valid = 1'b1;
      lif.digits_in  = d;
      lif.dp_in      = p;
      lif.blank_in   = b;
      @(negedge clk);
      lif.load_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset           = 1'b1;
      bright          = 4'd15;
      lz_en           = 1'b0;
      lif.load_valid  = 1'b0;
      lif.digits_in   = '0;
      lif.dp_in       = '0;
      lif.blank_in    = '0;
      lif8.load_valid = 1'b0;
      lif8.digits_in  = '0;
      lif8.dp_in      = '0;
      lif8.blank_in   = '0;
      #12;
      n_checks++;
      if ({an, seg, dp, frame_tick, lif.load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_hold: got an=%b seg=%h dp=%b ft=%b rdy=%b, want 1111 7f 1 0 1",
                  an, seg, dp, frame_tick, lif.load_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({an, seg, dp, frame_tick, lif.load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_first_cycle: got an=%b seg=%h dp=%b ft=%b rdy=%b, want 1111 7f 1 0 1",
                  an, seg, dp, frame_tick, lif.load_ready);
      end
   endtask

   task automatic test_display;
      logic [3:0] an_code [4];
      logic [6:0] exp_seg [4];
      logic       exp_dp  [4];
      an_code = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
      exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1};
      @(negedge clk);
      lif.load_valid = 1'b1;
      lif.digits_in  = 16'h12AF;
      lif.dp_in      = 4'b0010;
      lif.blank_in   = 4'b0000;
      n_checks++;
      if (lif.load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL load_ready_idle: got %b, want 1", lif.load_ready);
      end
      @(negedge clk);
      lif.load_valid = 1'b0;
      n_checks++;
      if (lif.load_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL load_ready_after_xfer: got %b, want 0", lif.load_ready);
      end
      wait_tick(1'b0, 200);
      for (int d = 0; d < 4; d++) begin
         for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            n_checks++;
            if ({an, seg, dp, frame_tick} !==
                {an_code[d], exp_seg[d], exp_dp[d], (d == 3 && s == 15)}) begin
               n_fail++;
               $display("FAIL display d%0d s%0d: got an=%b seg=%h dp=%b ft=%b, want an=%b seg=%h dp=%b",
                        d, s, an, seg, dp, frame_tick, an_code[d], exp_seg[d], exp_dp[d]);
            end
         end
      end
   endtask

   task automatic test_handshake;
      @(negedge clk);
      lif.load_valid = 1'b1;
      lif.digits_in  = 16'h3456;
      lif.dp_in      = 4'b0000;
      lif.blank_in   = 4'b0000;
      @(negedge clk);
      lif.digits_in  = 16'h789A;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (lif.load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_while_full %0d: got %b, want 0", i, lif.load_ready);
         end
         @(negedge clk);
      end
      lif.load_valid = 1'b0;
      wait_tick(1'b0, 200);
      n_checks++;
      if (lif.load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_at_tick: got %b, want 1", lif.load_ready);
      end
      @(negedge clk);
      n_checks++;
      if ({an, seg, lif.load_ready} !== {4'b1110, 7'h02, 1'b1}) begin
         n_fail++;
         $display("FAIL frame_a_shown: got an=%b seg=%h rdy=%b, want an=1110 seg=02 rdy=1",
                  an, seg, lif.load_ready);
      end
      lif.load_valid = 1'b1;
      @(negedge clk);
      lif.load_valid = 1'b0;
      n_checks++;
      if (lif.load_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_b_accepted: got ready %b, want 0", lif.load_ready);
      end
      wait_tick(1'b0, 200);
      @(negedge clk);
      n_checks++;
      if ({an, seg} !== {4'b1110, 7'h08}) begin
         n_fail++;
         $display("FAIL frame_b_shown: got an=%b seg=%h, want an=1110 seg=08", an, seg);
      end
   endtask

   task automatic test_lz;
      logic [3:0] an_code [4];
      logic [6:0] seg_70 [4];
      logic       lit;
      an_code = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      seg_70  = '{7'h40, 7'h78, 7'h40, 7'h40};
      lz_en   = 1'b1;
      load4(16'h0070, 4'b0000, 4'b0000);
      wait_tick(1'b0, 200);
      for (int d = 0; d < 4; d++) begin
         for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            lit = (d < 2);
            n_checks++;
            if ({an, seg, dp} !== {lit ? an_code[d] : 4'hF, lit ? seg_70[d] : 7'h7F, 1'b1}) begin
               n_fail++;
               $display("FAIL lz_0070 d%0d s%0d: got an=%b seg=%h dp=%b, want lit=%b",
                        d, s, an, seg, dp, lit);
            end
         end
      end
      load4(16'h0000, 4'b0000, 4'b0000);
      wait_tick(1'b0, 200);
      for (int d = 0; d < 4; d++) begin
         for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            lit = (d == 0);
            n_checks++;
            if ({an, seg, dp} !== {lit ? 4'b1110 : 4'hF, lit ? 7'h40 : 7'h7F, 1'b1}) begin
               n_fail++;
               $display("FAIL lz_0000 d%0d s%0d: got an=%b seg=%h dp=%b, want lit=%b",
                        d, s, an, seg, dp, lit);
            end
         end
      end
   endtask

   task automatic test_bright;
      logic [3:0] an_code [4];
      logic       lit;
      an_code = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      lz_en   = 1'b0;
      bright  = 4'd3;
      wait_tick(1'b0, 200);
      for (int d = 0; d < 4; d++) begin
         for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            // Raised mid-slot of digit 1; takes hold from digit 2's slot start.
            lit = (d < 2) ? (s <= 3) : 1'b1;
            n_checks++;
            if ({an, seg, dp} !== {lit ? an_code[d] : 4'hF, lit ? 7'h40 : 7'h7F, 1'b1}) begin
               n_fail++;
               $display("FAIL bright d%0d s%0d: got an=%b seg=%h dp=%b, want lit=%b",
                        d, s, an, seg, dp, lit);
            end
            if (d == 1 && s == 8) bright = 4'd15;
         end
      end
   endtask

   task automatic test_reset_mid;
      load4(16'h8888, 4'b1111, 4'b0000);
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({an, seg, dp, frame_tick, lif.load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_async: got an=%b seg=%h dp=%b ft=%b rdy=%b, want 1111 7f 1 0 1",
                  an, seg, dp, frame_tick, lif.load_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({an, seg, dp, lif.load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_after: got an=%b seg=%h dp=%b rdy=%b, want 1111 7f 1 1",
                  an, seg, dp, lif.load_ready);
      end
      wait_tick(1'b0, 200);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         n_checks++;
         if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL pending_discarded cyc%0d: got an=%b seg=%h dp=%b, want 1111 7f 1",
                     i, an, seg, dp);
         end
      end
   endtask

   task automatic test_wide;
      logic [7:0] an_code [8];
      logic [6:0] exp_seg [8];
      int         d;
      an_code = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      exp_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
      @(negedge clk);
      lif8.load_valid = 1'b1;
      lif8.digits_in  = 32'h7654_3210;
      lif8.dp_in      = 8'h00;
      lif8.blank_in   = 8'h00;
      @(negedge clk);
      lif8.load_valid = 1'b0;
      n_checks++;
      if (lif8.load_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL wide_xfer: got ready %b, want 0", lif8.load_ready);
      end
      wait_tick(1'b1, 600);
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         d = i / 32;
         n_checks++;
         if ({an8, seg8, dp8, frame_tick8} !== {an_code[d], exp_seg[d], 1'b1, (i == 255)}) begin
            n_fail++;
            $display("FAIL wide cyc%0d: got an=%b seg=%h dp=%b ft=%b, want an=%b seg=%h ft=%b",
                     i, an8, seg8, dp8, frame_tick8, an_code[d], exp_seg[d], (i == 255));
         end
      end
      @(negedge clk);
      n_checks++;
      if ({an8, seg8} !== {8'hFE, 7'h40}) begin
         n_fail++;
         $display("FAIL wide_wrap: got an=%b seg=%h, want an=11111110 seg=40", an8, seg8);
      end
   endtask

   initial begin
      test_reset();
      test_display();
      test_handshake();
      test_lz();
      test_bright();
      test_reset_mid();
      test_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
